video_scandoubler: RTL and testbench

- Line-doubling stage directly downstream of the palette/frame mixer.
- Captures the blanked 6-bit colour stream at TV pixel rate into a ping-pong line buffer.
- Replays each captured line twice at double pixel rate, giving VGA-rate (31.25 kHz) output.
- Generates VGA hsync and line-aligned vsync. Output feeds the DAC/output mux.

---
 rtl/video_scandoubler_if.sv | 22 ++
 rtl/video_scandoubler.sv | 122 ++++++++++++
 tb/tb_video_scandoubler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/video_scandoubler_if.sv
// Port bundle for the scandoubler: TV-rate capture inputs and VGA-rate outputs.
// The master drives the capture side (mixer/bench); the slave is the doubler.
interface video_scandoubler_if;
  logic       tv_stb;
  logic       vga_stb;
  logic       tv_line_start;
  logic       tv_vsync;
  logic [5:0] color;
  logic [5:0] vga_color;
  logic       vga_hsync;
  logic       vga_vsync;

  modport master (
    output tv_stb, vga_stb, tv_line_start, tv_vsync, color,
    input  vga_color, vga_hsync, vga_vsync
  );

  modport slave (
    input  tv_stb, vga_stb, tv_line_start, tv_vsync, color,
    output vga_color, vga_hsync, vga_vsync
  );
endinterface

// File: rtl/video_scandoubler.sv
// Line doubler: captures a TV line into one bank of a ping-pong buffer while the
// other bank is replayed twice at VGA pixel rate with generated hsync/vsync.
module video_scandoubler #(
  parameter int LINE_LEN  = 448,
  parameter int HSYNC_LEN = 54,
  parameter int AW        = 9
) (
  input  logic               clk,
  input  logic               rst,
  video_scandoubler_if.slave vid
);
  localparam int            HW       = $clog2(HSYNC_LEN + 1);
  localparam logic [AW-1:0] LAST     = AW'(LINE_LEN - 1);
  localparam logic [AW:0]   FULL_LEN = (AW+1)'(LINE_LEN);

  logic [5:0]    mem [2][LINE_LEN];

  logic [AW-1:0] wr_ptr;
  logic          wr_full;
  logic          wbank;
  logic [AW-1:0] rd_ptr;
  logic          pass;
  logic          done;
  logic          valid;
  logic          started;
  logic [AW:0]   rd_len;
  logic [HW-1:0] hs_cnt;

  logic          ls;
  logic [AW:0]   wr_count;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_bank;
  logic [AW-1:0] rd_ptr_c;
  logic          pass_c;
  logic          done_c;
  logic          valid_c;
  logic [AW:0]   rd_len_c;
  logic [HW-1:0] hs_cnt_c;
  logic          rd_en;
  logic          rd_hit;
  logic          rd_wrap;

  // A line start overrides the read state in its own cycle, so a coincident
  // VGA strobe already reads address 0 of the freshly swapped bank.
  always_comb begin
    ls       = vid.tv_stb & vid.tv_line_start;
    wr_count = wr_full ? FULL_LEN : {1'b0, wr_ptr};
    wr_bank  = ls ? ~wbank : wbank;
    wr_addr  = ls ? '0 : wr_ptr;
    wr_en    = vid.tv_stb & (ls | ~wr_full);
    rd_bank  = ls ? wbank : ~wbank;
    rd_ptr_c = ls ? '0 : rd_ptr;
    pass_c   = ls ? 1'b0 : pass;
    done_c   = ls ? 1'b0 : done;
    valid_c  = ls ? started : valid;
    rd_len_c = ls ? wr_count : rd_len;
    hs_cnt_c = ls ? HW'(HSYNC_LEN) : hs_cnt;
    rd_en    = vid.vga_stb & ~done_c;
    rd_hit   = rd_en & valid_c & ({1'b0, rd_ptr_c} < rd_len_c);
    rd_wrap  = rd_en & (rd_ptr_c == LAST);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= vid.color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      wr_full       <= 1'b0;
      wbank         <= 1'b0;
      rd_ptr        <= '0;
      pass          <= 1'b0;
      done          <= 1'b1;
      valid         <= 1'b0;
      started       <= 1'b0;
      rd_len        <= '0;
      hs_cnt        <= '0;
      vid.vga_color <= '0;
      vid.vga_hsync <= 1'b0;
      vid.vga_vsync <= 1'b0;
    end else begin
      valid  <= valid_c;
      rd_len <= rd_len_c;
      rd_ptr <= rd_ptr_c;
      pass   <= pass_c;
      done   <= done_c;
      hs_cnt <= hs_cnt_c;

      if (ls) begin
        wbank         <= ~wbank;
        wr_ptr        <= AW'(1);
        wr_full       <= 1'b0;
        started       <= 1'b1;
        vid.vga_vsync <= vid.tv_vsync;
      end else if (wr_en) begin
        if (wr_ptr == LAST) wr_full <= 1'b1;
        else                wr_ptr  <= wr_ptr + AW'(1);
      end

      if (rd_en) begin
        if (rd_wrap) begin
          rd_ptr <= '0;
          pass   <= ~pass_c;
          if (pass_c) done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr_c + AW'(1);
        end
      end

      // Pixels past the captured length of a short line read as black.
      if (vid.vga_stb) begin
        vid.vga_color <= rd_hit ? mem[rd_bank][rd_ptr_c] : '0;
        vid.vga_hsync <= (hs_cnt_c != '0);
        if (rd_wrap & ~pass_c)    hs_cnt <= HW'(HSYNC_LEN);
        else if (hs_cnt_c != '0)  hs_cnt <= hs_cnt_c - HW'(1);
      end
    end
  end
endmodule

// File: tb/tb_video_scandoubler.sv
// Directed bench for the scandoubler: full, alternating and short lines,
// hsync shape, vsync alignment and mid-replay reset recovery.
module tb_video_scandoubler;
  localparam int LINE_LEN  = 448;
  localparam int HSYNC_LEN = 54;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_scandoubler_if vid ();

  video_scandoubler dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  int checks = 0;
  int errors = 0;

  logic [5:0] col_q [$];
  logic       hs_q  [$];
  logic       vs_q  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // One sample per VGA strobe, taken just after the updating edge.
  always @(posedge clk) begin
    if (vid.vga_stb === 1'b1 && rst === 1'b0) begin
      #1;
      col_q.push_back(vid.vga_color);
      hs_q.push_back(vid.vga_hsync);
      vs_q.push_back(vid.vga_vsync);
    end
  end

  function automatic logic [5:0] wcol(input int m, input int i);
    case (m)
      0:       return 6'(i);
      1:       return 6'h15;
      2:       return 6'h2A;
      3:       return 6'(i + 7);
      4:       return 6'h3F;
      default: return 6'(i * 3);
    endcase
  endfunction

  // n TV pixels, each a 4-clock slot: tv_stb, vga_stb, idle, vga_stb.
  task automatic run_line(input int m, input int n, input bit ls, input int vs_at);
    col_q.delete();
    hs_q.delete();
    vs_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vid.tv_stb        = 1'b1;
      vid.tv_line_start = ls && (i == 0);
      vid.color         = wcol(m, i);
      vid.vga_stb       = 1'b0;
      if (i == vs_at) vid.tv_vsync = ~vid.tv_vsync;
      @(negedge clk);
      vid.tv_stb        = 1'b0;
      vid.tv_line_start = 1'b0;
      vid.vga_stb       = 1'b1;
      @(negedge clk);
      vid.vga_stb       = 1'b0;
      @(negedge clk);
      vid.vga_stb       = 1'b1;
    end
    @(negedge clk);
    vid.vga_stb = 1'b0;
    @(negedge clk);
  endtask

  // Expected replay of the previous line (write mode pm, plen pixels captured).
  task automatic check_line(input string tag, input int pm, input int plen, input bit vld,
                            input bit hs_on, input bit vs_want, input int ns);
    chk({tag, ".nsamp"}, col_q.size(), ns);
    for (int j = 0; j < col_q.size() && j < ns; j++) begin
      int p;
      p = j % LINE_LEN;
      chk($sformatf("%s.col[%0d]", tag, j), col_q[j], (vld && p < plen) ? wcol(pm, p) : 6'h00);
      chk($sformatf("%s.hs[%0d]", tag, j), hs_q[j], hs_on && (p < HSYNC_LEN));
      chk($sformatf("%s.vs[%0d]", tag, j), vs_q[j], vs_want);
    end
  endtask

  initial begin
    rst               = 1'b1;
    vid.tv_stb        = 1'b0;
    vid.vga_stb       = 1'b0;
    vid.tv_line_start = 1'b0;
    vid.tv_vsync      = 1'b0;
    vid.color         = 6'h00;
    repeat (3) @(negedge clk);
    chk("rst.col", vid.vga_color, 6'h00);
    chk("rst.hs",  vid.vga_hsync, 1'b0);
    chk("rst.vs",  vid.vga_vsync, 1'b0);
    rst = 1'b0;

    // Address ramp lines: first replay is blank, then the ramp twice per line.
    run_line(0, LINE_LEN, 1'b1, -1);
    check_line("L0", 0, LINE_LEN, 1'b0, 1'b1, 1'b0, 2 * LINE_LEN);
    run_line(0, LINE_LEN, 1'b1, -1);
    check_line("L1", 0, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);
    run_line(0, LINE_LEN, 1'b1, -1);
    check_line("L2", 0, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);

    // Alternating constant lines.
    run_line(1, LINE_LEN, 1'b1, -1);
    check_line("L3", 0, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);
    run_line(2, LINE_LEN, 1'b1, -1);
    check_line("L4", 1, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);
    run_line(1, LINE_LEN, 1'b1, -1);
    check_line("L5", 2, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);

    // Short 300-pixel line cuts the replay of L5; its own replay pads with 0.
    run_line(3, 300, 1'b1, -1);
    check_line("L6", 1, LINE_LEN, 1'b1, 1'b1, 1'b0, 600);
    run_line(4, LINE_LEN, 1'b1, 100);
    check_line("L7", 3, 300, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);

    // vsync raised mid-L7 appears only from the L8 line start.
    run_line(4, 200, 1'b1, -1);
    check_line("L8", 4, LINE_LEN, 1'b1, 1'b1, 1'b1, 400);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst.col", vid.vga_color, 6'h00);
    chk("mid_rst.hs",  vid.vga_hsync, 1'b0);
    chk("mid_rst.vs",  vid.vga_vsync, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    vid.tv_vsync = 1'b0;

    run_line(4, LINE_LEN - 200, 1'b0, -1);
    check_line("post_rst", 0, 0, 1'b0, 1'b0, 1'b0, 2 * (LINE_LEN - 200));
    run_line(5, LINE_LEN, 1'b1, -1);
    check_line("R0", 5, LINE_LEN, 1'b0, 1'b1, 1'b0, 2 * LINE_LEN);
    run_line(1, LINE_LEN, 1'b1, -1);
    check_line("R1", 5, LINE_LEN, 1'b1, 1'b1, 1'b0, 2 * LINE_LEN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
